srr_builder: RTL and testbench

//  Front end of the SRR table: accepts row-tagged requests from the request queue, CAM-matches each hit tag, then opens a new SRR entry or appends to an existing one.

---
 rtl/srr_builder.sv | 198 +++++++++++++++++++
 tb/tb_srr_builder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/srr_builder.sv
// rtl/srr_builder.sv - SRR table front end: CAM match, open/append entry, next-pointer and chain upkeep
// Optional feature macro: SRR_BUILDER_STATS_EN (saturating hit/alloc/stall counters).
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 4
`endif
`ifndef HIT_TAG_WIDTH
`define HIT_TAG_WIDTH 8
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 2
`endif
`ifndef MAX_SRR_ENTRIES
`define MAX_SRR_ENTRIES 4
`endif

module srr_builder #(
  parameter int MAX_ENTRIES  = `MAX_SRR_ENTRIES,
  parameter int MAX_REQUESTS = 1 << `REQUEST_ID_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [`REQUEST_ID_WIDTH-1:0]  in_req_id,
  input  logic [`HIT_TAG_WIDTH-1:0]     in_hit_tag,
  input  logic                          clear_req,
  output logic                          clear_ack,
  output logic                          full_stall,
  output logic                          tbl_clear,
  output logic                          tbl_wr_en,
  output logic [`HIT_TAG_WIDTH-1:0]     tbl_wr_hit_tag,
  output logic [`REQUEST_ID_WIDTH-1:0]  tbl_wr_head_req,
  input  logic                          tbl_wr_full,
  input  logic [`SRR_ID_WIDTH-1:0]      tbl_num_entries,
  output logic                          tbl_upd_en,
  output logic [`SRR_ID_WIDTH-1:0]      tbl_upd_addr,
  output logic [`REQUEST_ID_WIDTH-1:0]  tbl_upd_count,
  output logic [`REQUEST_ID_WIDTH-1:0]  tbl_upd_tail_req,
  output logic                          tbl_chain_wr_en,
  output logic [`SRR_ID_WIDTH-1:0]      tbl_chain_wr_addr,
  output logic [`SRR_ID_WIDTH-1:0]      tbl_chain_wr_data,
  output logic [`SRR_ID_WIDTH-1:0]      tbl_rd_addr,
  input  logic [`REQUEST_ID_WIDTH-1:0]  tbl_rd_count,
  input  logic [`REQUEST_ID_WIDTH-1:0]  tbl_rd_tail_req,
  output logic                          tbl_cam_en,
  output logic [`HIT_TAG_WIDTH-1:0]     tbl_cam_tag,
  input  logic                          tbl_cam_hit,
  input  logic [`SRR_ID_WIDTH-1:0]      tbl_cam_hit_addr,
  input  logic [`REQUEST_ID_WIDTH-1:0]  nxt_rd_id,
  output logic [`REQUEST_ID_WIDTH-1:0]  nxt_rd_data,
  output logic                          nxt_rd_valid
`ifdef SRR_BUILDER_STATS_EN
  ,
  output logic [15:0]                   stat_hits,
  output logic [15:0]                   stat_allocs,
  output logic [15:0]                   stat_stall_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, LOOKUP, READ, ALLOC, CLEAR} state_t;

  state_t                         state, state_nxt;
  logic                           accept;
  logic                           alloc_ok;
  logic [`REQUEST_ID_WIDTH-1:0]   id_q;
  logic [`HIT_TAG_WIDTH-1:0]      tag_q;
  logic [`SRR_ID_WIDTH-1:0]       last_alloc;
  logic                           last_alloc_valid;
  logic [`REQUEST_ID_WIDTH-1:0]   nxt_data [MAX_REQUESTS];
  logic [MAX_REQUESTS-1:0]        nxt_valid;

  // An occupancy index outside the configured depth is treated as full too.
  assign alloc_ok = !tbl_wr_full && (int'(tbl_num_entries) < MAX_ENTRIES);

  assign nxt_rd_valid = nxt_valid[nxt_rd_id];
  assign nxt_rd_data  = nxt_rd_valid ? nxt_data[nxt_rd_id] : '0;

  always_comb begin
    state_nxt         = state;
    in_ready          = 1'b0;
    accept            = 1'b0;
    clear_ack         = 1'b0;
    full_stall        = 1'b0;
    tbl_clear         = 1'b0;
    tbl_wr_en         = 1'b0;
    tbl_wr_hit_tag    = '0;
    tbl_wr_head_req   = '0;
    tbl_upd_en        = 1'b0;
    tbl_upd_addr      = '0;
    tbl_upd_count     = '0;
    tbl_upd_tail_req  = '0;
    tbl_chain_wr_en   = 1'b0;
    tbl_chain_wr_addr = '0;
    tbl_chain_wr_data = '0;
    tbl_cam_en        = 1'b0;
    tbl_cam_tag       = '0;
    case (state)
      IDLE: begin
        in_ready = !clear_req;
        if (clear_req) begin
          state_nxt = CLEAR;
        end else if (in_valid) begin
          accept    = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        tbl_cam_en  = 1'b1;
        tbl_cam_tag = tag_q;
        state_nxt   = tbl_cam_hit ? READ : ALLOC;
      end
      READ: begin
        // A saturated count cannot take another request; split the row into a new entry.
        if (&tbl_rd_count) begin
          state_nxt = ALLOC;
        end else begin
          tbl_upd_en       = 1'b1;
          tbl_upd_addr     = tbl_rd_addr;
          tbl_upd_count    = tbl_rd_count + 1'b1;
          tbl_upd_tail_req = id_q;
          state_nxt        = IDLE;
        end
      end
      ALLOC: begin
        if (!alloc_ok) begin
          full_stall = 1'b1;
          if (clear_req) state_nxt = CLEAR;
        end else begin
          tbl_wr_en         = 1'b1;
          tbl_wr_hit_tag    = tag_q;
          tbl_wr_head_req   = id_q;
          tbl_chain_wr_en   = last_alloc_valid;
          tbl_chain_wr_addr = last_alloc_valid ? last_alloc : '0;
          tbl_chain_wr_data = last_alloc_valid ? tbl_num_entries : '0;
          state_nxt         = IDLE;
        end
      end
      CLEAR: begin
        tbl_clear = 1'b1;
        clear_ack = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      id_q             <= '0;
      tag_q            <= '0;
      tbl_rd_addr      <= '0;
      last_alloc       <= '0;
      last_alloc_valid <= 1'b0;
      nxt_valid        <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        id_q  <= in_req_id;
        tag_q <= in_hit_tag;
      end
      if (tbl_cam_en && tbl_cam_hit) tbl_rd_addr <= tbl_cam_hit_addr;
      if (tbl_wr_en) begin
        last_alloc       <= tbl_num_entries;
        last_alloc_valid <= 1'b1;
      end
      if (tbl_clear) begin
        last_alloc_valid <= 1'b0;
        nxt_valid        <= '0;
      end else if (tbl_upd_en) begin
        nxt_valid[tbl_rd_tail_req] <= 1'b1;
        nxt_valid[id_q]            <= 1'b0;
      end else if (tbl_wr_en) begin
        nxt_valid[id_q] <= 1'b0;
      end
    end
  end

  // Pointer payload needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (tbl_upd_en) nxt_data[tbl_rd_tail_req] <= id_q;
  end

`ifdef SRR_BUILDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits         <= '0;
      stat_allocs       <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (tbl_upd_en && !(&stat_hits))         stat_hits         <= stat_hits + 16'd1;
      if (tbl_wr_en && !(&stat_allocs))        stat_allocs       <= stat_allocs + 16'd1;
      if (full_stall && !(&stat_stall_cycles)) stat_stall_cycles <= stat_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_srr_builder.sv
// tb/tb_srr_builder.sv - scoreboard bench for srr_builder with a small SRR table model
`timescale 1ns/1ps
`ifndef REQUEST_ID_WIDTH
`define REQUEST_ID_WIDTH 4
`endif
`ifndef HIT_TAG_WIDTH
`define HIT_TAG_WIDTH 8
`endif
`ifndef SRR_ID_WIDTH
`define SRR_ID_WIDTH 2
`endif
`ifndef MAX_SRR_ENTRIES
`define MAX_SRR_ENTRIES 4
`endif

module tb_srr_builder;
  localparam int RW = `REQUEST_ID_WIDTH;
  localparam int TW = `HIT_TAG_WIDTH;
  localparam int SW = `SRR_ID_WIDTH;
  localparam int ME = `MAX_SRR_ENTRIES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready;
  logic [RW-1:0] in_req_id = '0;
  logic [TW-1:0] in_hit_tag = '0;
  logic          clear_req = 1'b0, clear_ack, full_stall;
  logic          tbl_clear, tbl_wr_en, tbl_wr_full;
  logic [TW-1:0] tbl_wr_hit_tag, tbl_cam_tag;
  logic [RW-1:0] tbl_wr_head_req, tbl_upd_count, tbl_upd_tail_req, tbl_rd_count, tbl_rd_tail_req;
  logic [SW-1:0] tbl_num_entries, tbl_upd_addr, tbl_chain_wr_addr, tbl_chain_wr_data, tbl_rd_addr, tbl_cam_hit_addr;
  logic          tbl_upd_en, tbl_chain_wr_en, tbl_cam_en, tbl_cam_hit;
  logic [RW-1:0] nxt_rd_id = '0, nxt_rd_data;
  logic          nxt_rd_valid;
`ifdef SRR_BUILDER_STATS_EN
  logic [15:0]   stat_hits, stat_allocs, stat_stall_cycles;
`endif

  srr_builder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_req_id(in_req_id), .in_hit_tag(in_hit_tag), .clear_req(clear_req),
    .clear_ack(clear_ack), .full_stall(full_stall), .tbl_clear(tbl_clear),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_hit_tag(tbl_wr_hit_tag), .tbl_wr_head_req(tbl_wr_head_req),
    .tbl_wr_full(tbl_wr_full), .tbl_num_entries(tbl_num_entries),
    .tbl_upd_en(tbl_upd_en), .tbl_upd_addr(tbl_upd_addr), .tbl_upd_count(tbl_upd_count),
    .tbl_upd_tail_req(tbl_upd_tail_req), .tbl_chain_wr_en(tbl_chain_wr_en),
    .tbl_chain_wr_addr(tbl_chain_wr_addr), .tbl_chain_wr_data(tbl_chain_wr_data),
    .tbl_rd_addr(tbl_rd_addr), .tbl_rd_count(tbl_rd_count), .tbl_rd_tail_req(tbl_rd_tail_req),
    .tbl_cam_en(tbl_cam_en), .tbl_cam_tag(tbl_cam_tag), .tbl_cam_hit(tbl_cam_hit),
    .tbl_cam_hit_addr(tbl_cam_hit_addr), .nxt_rd_id(nxt_rd_id), .nxt_rd_data(nxt_rd_data),
    .nxt_rd_valid(nxt_rd_valid)
`ifdef SRR_BUILDER_STATS_EN
    , .stat_hits(stat_hits), .stat_allocs(stat_allocs), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Attached table model: newest matching entry wins the CAM, reads follow tbl_rd_addr.
  logic [TW-1:0] m_tag  [ME];
  logic [RW-1:0] m_cnt  [ME];
  logic [RW-1:0] m_tail [ME];
  int            m_num = 0;
  logic          force_sat = 1'b0;

  always @* begin
    tbl_cam_hit      = 1'b0;
    tbl_cam_hit_addr = '0;
    for (int i = 0; i < ME; i++)
      if (tbl_cam_en && i < m_num && m_tag[i] == tbl_cam_tag) begin
        tbl_cam_hit      = 1'b1;
        tbl_cam_hit_addr = SW'(i);
      end
  end

  assign tbl_rd_count    = force_sat ? '1 : m_cnt[tbl_rd_addr];
  assign tbl_rd_tail_req = m_tail[tbl_rd_addr];
  assign tbl_wr_full     = (m_num >= ME);
  assign tbl_num_entries = SW'(m_num);

  always @(posedge clk) begin
    if (tbl_clear) begin
      m_num <= 0;
    end else begin
      if (tbl_wr_en && m_num < ME) begin
        m_tag[SW'(m_num)]  <= tbl_wr_hit_tag;
        m_cnt[SW'(m_num)]  <= RW'(1);
        m_tail[SW'(m_num)] <= tbl_wr_head_req;
        m_num              <= m_num + 1;
      end
      if (tbl_upd_en) begin
        m_cnt[tbl_upd_addr]  <= tbl_upd_count;
        m_tail[tbl_upd_addr] <= tbl_upd_tail_req;
      end
    end
  end

  // kind 1 = alloc (tag, head, chain_en, chain_addr, chain_data); 2 = update (addr, count, tail); 3 = clear
  typedef struct {int kind; int a; int b; int c; int d; int e;} exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    int   kind;
    forever begin
      @(negedge clk);
      if (rst_n && (tbl_wr_en || tbl_upd_en || clear_ack)) begin
        kind = tbl_wr_en ? 1 : (tbl_upd_en ? 2 : 3);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got op kind %0d expected none at %0t", kind, $time);
        end else begin
          e = sb.pop_front();
          chk("op_kind", kind, e.kind);
          if (e.kind == 1) begin
            chk("wr_tag", int'(tbl_wr_hit_tag), e.a);
            chk("wr_head", int'(tbl_wr_head_req), e.b);
            chk("chain_en", int'(tbl_chain_wr_en), e.c);
            chk("chain_addr", int'(tbl_chain_wr_addr), e.d);
            chk("chain_data", int'(tbl_chain_wr_data), e.e);
          end else if (e.kind == 2) begin
            chk("upd_addr", int'(tbl_upd_addr), e.a);
            chk("upd_count", int'(tbl_upd_count), e.b);
            chk("upd_tail", int'(tbl_upd_tail_req), e.c);
          end else begin
            chk("tbl_clear", int'(tbl_clear), 1);
          end
        end
      end
    end
  end

  // Returns just after the accepting edge, i.e. with the DUT in LOOKUP.
  task automatic send(input int id, input int tag);
    int w;
    w = 0;
    @(posedge clk); #1;
    in_valid   = 1'b1;
    in_req_id  = RW'(id);
    in_hit_tag = TW'(tag);
    @(negedge clk);
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic set_nxt_id(input int id);
    @(posedge clk); #1;
    nxt_rd_id = RW'(id);
  endtask

  task automatic wait_clear_ack();
    int w;
    w = 0;
    @(negedge clk);
    while (!clear_ack && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("clear_ack_seen", int'(clear_ack), 1);
    @(posedge clk); #1;
    clear_req = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_wr_en", int'(tbl_wr_en), 0);
    chk("rst_upd_en", int'(tbl_upd_en), 0);
    chk("rst_full_stall", int'(full_stall), 0);
    chk("rst_cam_en", int'(tbl_cam_en), 0);
    chk("rst_rd_addr", int'(tbl_rd_addr), 0);
    chk("rst_nxt_valid", int'(nxt_rd_valid), 0);

    // First miss opens entry 0, no chain write, in_ready low for two cycles.
    sb.push_back('{1, 'h10, 3, 0, 0, 0});
    send(3, 'h10);
    @(negedge clk); chk("rdy_lookup", int'(in_ready), 0); chk("wr_lat1", int'(tbl_wr_en), 0);
    @(negedge clk); chk("rdy_alloc", int'(in_ready), 0); chk("wr_lat2", int'(tbl_wr_en), 1);
    @(negedge clk); chk("rdy_back", int'(in_ready), 1);

    // Hit appends: count 2, tail 5, nxt[3]=5 visible only after the write cycle.
    sb.push_back('{2, 0, 2, 5, 0, 0});
    set_nxt_id(3);
    send(5, 'h10);
    @(negedge clk);
    @(negedge clk); chk("nxt_same_cycle_old", int'(nxt_rd_valid), 0);
    @(negedge clk); chk("nxt3_data", int'(nxt_rd_data), 5); chk("nxt3_valid", int'(nxt_rd_valid), 1);

    // Second miss chains entry 0 -> 1.
    sb.push_back('{1, 'h20, 6, 1, 0, 1});
    send(6, 'h20);
    repeat (2) @(negedge clk);
    set_nxt_id(6);
    @(negedge clk); chk("nxt6_valid", int'(nxt_rd_valid), 0);

    // Saturated count on a hit splits into a new entry 2 chained from 1.
    force_sat = 1'b1;
    sb.push_back('{1, 'h10, 7, 1, 1, 2});
    send(7, 'h10);
    repeat (3) @(negedge clk);
    force_sat = 1'b0;
    sb.push_back('{2, 2, 2, 8, 0, 0});
    send(8, 'h10);
    repeat (2) @(negedge clk);
    set_nxt_id(7);
    @(negedge clk); chk("nxt7_data", int'(nxt_rd_data), 8); chk("nxt7_valid", int'(nxt_rd_valid), 1);

    // Fill the table, then a miss stalls until a clear.
    sb.push_back('{1, 'h30, 9, 1, 2, 3});
    send(9, 'h30);
    repeat (2) @(negedge clk);
    send(10, 'h40);
    repeat (3) @(negedge clk);
    chk("full_stall", int'(full_stall), 1);
    chk("stall_in_ready", int'(in_ready), 0);
    chk("stall_no_wr", int'(tbl_wr_en), 0);
    sb.push_back('{3, 0, 0, 0, 0, 0});
    @(posedge clk); #1 clear_req = 1'b1;
    wait_clear_ack();
    nxt_rd_id = RW'(3);
    @(negedge clk);
    chk("post_clear_in_ready", int'(in_ready), 1);
    chk("post_clear_stall", int'(full_stall), 0);
    chk("post_clear_nxt3", int'(nxt_rd_valid), 0);

    // New batch: no chain on first alloc; clear raised during LOOKUP lets the request finish.
    sb.push_back('{1, 'h50, 1, 0, 0, 0});
    send(1, 'h50);
    repeat (2) @(negedge clk);
    sb.push_back('{2, 0, 2, 2, 0, 0});
    send(2, 'h50);
    repeat (2) @(negedge clk);
    set_nxt_id(1);
    @(negedge clk); chk("nxt1_valid", int'(nxt_rd_valid), 1); chk("nxt1_data", int'(nxt_rd_data), 2);
    sb.push_back('{2, 0, 3, 4, 0, 0});
    sb.push_back('{3, 0, 0, 0, 0, 0});
    send(4, 'h50);
    clear_req = 1'b1;
    @(negedge clk); chk("ack_lookup", int'(clear_ack), 0);
    @(negedge clk); chk("ack_read", int'(clear_ack), 0); chk("upd_before_clear", int'(tbl_upd_en), 1);
    @(negedge clk); chk("ack_plus1", int'(clear_ack), 0);
    @(negedge clk); chk("ack_plus2", int'(clear_ack), 1);
    @(posedge clk); #1 clear_req = 1'b0;
    @(negedge clk); chk("cl_nxt1_valid", int'(nxt_rd_valid), 0);
    set_nxt_id(2);
    @(negedge clk); chk("cl_nxt2_valid", int'(nxt_rd_valid), 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
